// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: pixel strobe in, sync/qualifier/coordinate/event outputs.
// The generator uses the master modport; display consumers use the slave modport.
interface vga_timing_gen_if #(
   parameter int unsigned X_W     = 10,
   parameter int unsigned Y_W     = 10,
   parameter int unsigned FRAME_W = 16
) ();
   logic               i_pix_stb;
   logic               o_hs;
   logic               o_vs;
   logic               o_active;
   logic               o_blanking;
   logic [X_W-1:0]     o_x;
   logic [Y_W-1:0]     o_y;
   logic               o_line_end;
   logic               o_animate;
   logic               o_frame_end;
   logic [FRAME_W-1:0] o_frame;

   modport master (
      input  i_pix_stb,
      output o_hs, o_vs, o_active, o_blanking, o_x, o_y,
             o_line_end, o_animate, o_frame_end, o_frame
   );

   modport slave (
      output i_pix_stb,
      input  o_hs, o_vs, o_active, o_blanking, o_x, o_y,
             o_line_end, o_animate, o_frame_end, o_frame
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters advanced by the pixel strobe,
// with sync, visibility, coordinates and line/frame event strobes decoded from them.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned X_W      = 10,
   parameter int unsigned Y_W      = 10,
   parameter int unsigned FRAME_W  = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   vga_timing_gen_if.master vif
);
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_W      = $clog2(H_TOTAL);
   localparam int unsigned V_W      = $clog2(V_TOTAL);
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   logic [H_W-1:0]     h;
   logic [V_W-1:0]     v;
   logic [FRAME_W-1:0] frame;
   logic [31:0]        h_ext;
   logic [31:0]        v_ext;
   logic               h_last;
   logic               v_last;
   logic               v_anim;
   logic               h_vis;
   logic               v_vis;
   logic               adv_c;

   // Position decode, compared at 32 bits so window ends equal to the total never truncate
   always_comb begin
      h_ext  = 32'(h);
      v_ext  = 32'(v);
      h_last = (h_ext == H_TOTAL - 1);
      v_last = (v_ext == V_TOTAL - 1);
      v_anim = (v_ext == V_ACTIVE - 1);
      h_vis  = (h_ext < H_ACTIVE);
      v_vis  = (v_ext < V_ACTIVE);
      adv_c  = vif.i_pix_stb & ~i_rst;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         h     <= '0;
         v     <= '0;
         frame <= '0;
      end else if (vif.i_pix_stb) begin
         if (h_last) begin
            h <= '0;
            if (v_last) begin
               v     <= '0;
               frame <= frame + FRAME_W'(1);
            end else begin
               v <= v + V_W'(1);
            end
         end else begin
            h <= h + H_W'(1);
         end
      end
   end

   always_comb begin
      vif.o_hs        = ((h_ext >= HS_START) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
      vif.o_vs        = ((v_ext >= VS_START) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
      vif.o_active    = h_vis & v_vis;
      vif.o_blanking  = ~(h_vis & v_vis);
      vif.o_x         = h_vis ? X_W'(h) : '0;
      // Hold the last visible line through vertical blanking for downstream renderers
      vif.o_y         = v_vis ? Y_W'(v) : Y_W'(V_ACTIVE - 1);
      vif.o_line_end  = adv_c & h_last;
      vif.o_animate   = adv_c & h_last & v_anim;
      vif.o_frame_end = adv_c & h_last & v_last;
      vif.o_frame     = frame;
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: raster model from an absolute pixel index checked every
// cycle on three instances, plus hand-computed literal expectations.
module tb_vga_timing_gen;
   logic i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic rst_a, rst_b, rst_c;

   vga_timing_gen_if #(.X_W(2), .Y_W(2), .FRAME_W(2)) ifa ();
   vga_timing_gen_if #(.X_W(10), .Y_W(2), .FRAME_W(16)) ifb ();
   vga_timing_gen_if ifc ();

   // Small mode 4/1/2/1 x 3/1/1/1, vsync active-high, 2-bit frame counter
   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b1), .X_W(2), .Y_W(2), .FRAME_W(2)
   ) dut_a (.i_clk(i_clk), .i_rst(rst_a), .vif(ifa.master));

   // Full 800-pixel line timing with a short 8-line frame
   vga_timing_gen #(
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .Y_W(2)
   ) dut_b (.i_clk(i_clk), .i_rst(rst_b), .vif(ifb.master));

   vga_timing_gen dut_c (.i_clk(i_clk), .i_rst(rst_c), .vif(ifc.master));

   typedef struct {
      int hs; int vs; int act; int x; int y; int le; int an; int fe; int fr;
   } exp_t;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int na = 0, nb = 0, nc = 0;
   exp_t ea, eb, ec;

   int cyc_a, le_a, hsl_a, vsh_a;
   int fe_cyc_a[$];
   int an_cyc_a[$];
   int x_hist[96];
   int y_hist[96];
   int act_hist[96];
   int cyc_b, le_b, hsl_b, vsl_b, hsf_b;
   int fe_cyc_b[$];
   int cyc_c, le_c, hsl_c, vsl_c, hsf_c;

   // Expected outputs from the absolute count of consumed pixel strobes since reset
   function automatic exp_t exp_f(input int n, input int ha, input int hf, input int hsw,
                                  input int hb, input int va, input int vf, input int vsw,
                                  input int vb, input int hp, input int vp, input int fw,
                                  input int stb, input int rst);
      exp_t e;
      int ht, vt, h, v, ev;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      h  = n % ht;
      v  = (n / ht) % vt;
      e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : 1 - hp;
      e.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : 1 - vp;
      e.act = (h < ha && v < va) ? 1 : 0;
      e.x   = (h < ha) ? h : 0;
      e.y   = (v < va) ? v : va - 1;
      ev    = (stb != 0 && rst == 0 && h == ht - 1) ? 1 : 0;
      e.le  = ev;
      e.an  = (ev != 0 && v == va - 1) ? 1 : 0;
      e.fe  = (ev != 0 && v == vt - 1) ? 1 : 0;
      e.fr  = (n / (ht * vt)) % (1 << fw);
      return e;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_all(input string t, input exp_t e, input logic hs, input logic vs,
                          input logic act, input logic blk, input logic [31:0] x,
                          input logic [31:0] y, input logic le, input logic an,
                          input logic fe, input logic [31:0] fr);
      cmp({t, ".hs"}, 32'(hs), e.hs);
      cmp({t, ".vs"}, 32'(vs), e.vs);
      cmp({t, ".active"}, 32'(act), e.act);
      cmp({t, ".blanking"}, 32'(blk), 1 - e.act);
      cmp({t, ".x"}, x, e.x);
      cmp({t, ".y"}, y, e.y);
      cmp({t, ".line_end"}, 32'(le), e.le);
      cmp({t, ".animate"}, 32'(an), e.an);
      cmp({t, ".frame_end"}, 32'(fe), e.fe);
      cmp({t, ".frame"}, fr, e.fr);
   endtask

   // Model position advances with the same consumed strobes as the DUTs
   always @(posedge i_clk) begin
      na <= rst_a ? 0 : (ifa.i_pix_stb ? na + 1 : na);
      nb <= rst_b ? 0 : (ifb.i_pix_stb ? nb + 1 : nb);
      nc <= rst_c ? 0 : (ifc.i_pix_stb ? nc + 1 : nc);
   end

   always @(negedge i_clk) begin
      if (chk_en) begin
         ea = exp_f(na, 4, 1, 2, 1, 3, 1, 1, 1, 0, 1, 2, 32'(ifa.i_pix_stb), 32'(rst_a));
         cmp_all("a", ea, ifa.o_hs, ifa.o_vs, ifa.o_active, ifa.o_blanking, 32'(ifa.o_x),
                 32'(ifa.o_y), ifa.o_line_end, ifa.o_animate, ifa.o_frame_end, 32'(ifa.o_frame));
         eb = exp_f(nb, 640, 16, 96, 48, 4, 1, 2, 1, 0, 0, 16, 32'(ifb.i_pix_stb), 32'(rst_b));
         cmp_all("b", eb, ifb.o_hs, ifb.o_vs, ifb.o_active, ifb.o_blanking, 32'(ifb.o_x),
                 32'(ifb.o_y), ifb.o_line_end, ifb.o_animate, ifb.o_frame_end, 32'(ifb.o_frame));
         ec = exp_f(nc, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 16, 32'(ifc.i_pix_stb), 32'(rst_c));
         cmp_all("c", ec, ifc.o_hs, ifc.o_vs, ifc.o_active, ifc.o_blanking, 32'(ifc.o_x),
                 32'(ifc.o_y), ifc.o_line_end, ifc.o_animate, ifc.o_frame_end, 32'(ifc.o_frame));
      end
      if (cyc_a < 96) begin
         x_hist[cyc_a]   = 32'(ifa.o_x);
         y_hist[cyc_a]   = 32'(ifa.o_y);
         act_hist[cyc_a] = 32'(ifa.o_active);
      end
      if (ifa.o_line_end) le_a++;
      if (ifa.o_frame_end) fe_cyc_a.push_back(cyc_a);
      if (ifa.o_animate) an_cyc_a.push_back(cyc_a);
      if (!ifa.o_hs) hsl_a++;
      if (ifa.o_vs) vsh_a++;
      cyc_a++;
      if (ifb.o_line_end) le_b++;
      if (ifb.o_frame_end) fe_cyc_b.push_back(cyc_b);
      if (!ifb.o_hs) hsl_b++;
      if (!ifb.o_vs) vsl_b++;
      if (!ifb.o_hs && hsf_b < 0) hsf_b = cyc_b;
      cyc_b++;
      if (ifc.o_line_end) le_c++;
      if (!ifc.o_hs) hsl_c++;
      if (!ifc.o_vs) vsl_c++;
      if (!ifc.o_hs && hsf_c < 0) hsf_c = cyc_c;
      cyc_c++;
   end

   task automatic clr_a();
      cyc_a = 0; le_a = 0; hsl_a = 0; vsh_a = 0;
      fe_cyc_a.delete();
      an_cyc_a.delete();
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      @(posedge i_clk); #1;
      rst_a = 1'b0;
   endtask

   // mode 0: strobe every clock; mode 1: strobe on every third clock
   task automatic run_a(input int clocks, input int mode);
      clr_a();
      for (int k = 0; k < clocks; k++) begin
         ifa.i_pix_stb = (mode == 0) || (k % 3 == 2);
         @(posedge i_clk); #1;
      end
      ifa.i_pix_stb = 1'b0;
   endtask

   initial begin
      int xe[8];
      int fseq[5];
      xe   = '{0, 1, 2, 3, 0, 0, 0, 0};
      fseq = '{1, 2, 3, 0, 1};
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      ifa.i_pix_stb = 1'b0; ifb.i_pix_stb = 1'b0; ifc.i_pix_stb = 1'b0;
      cyc_a = 0; cyc_b = 0; cyc_c = 0; hsf_b = -1; hsf_c = -1;
      repeat (2) @(posedge i_clk);
      #1;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      chk_en = 1'b1;
      cmp("rst.hs", 32'(ifa.o_hs), 1);
      cmp("rst.vs", 32'(ifa.o_vs), 0);
      cmp("rst.active", 32'(ifa.o_active), 1);
      cmp("rst.frame", 32'(ifa.o_frame), 0);

      // Continuous strobe, two small frames
      run_a(96, 0);
      cmp("t1.line_end_cnt", 32'(le_a), 12);
      cmp("t1.frame_end_cnt", 32'(fe_cyc_a.size()), 2);
      if (fe_cyc_a.size() == 2) begin
         cmp("t1.frame_end_clk0", 32'(fe_cyc_a[0]), 47);
         cmp("t1.frame_end_clk1", 32'(fe_cyc_a[1]), 95);
      end
      cmp("t1.animate_cnt", 32'(an_cyc_a.size()), 2);
      if (an_cyc_a.size() > 0) cmp("t1.animate_clk0", 32'(an_cyc_a[0]), 23);
      cmp("t1.hs_low_cnt", 32'(hsl_a), 24);
      cmp("t1.vs_high_cnt", 32'(vsh_a), 16);
      cmp("t1.frame", 32'(ifa.o_frame), 2);
      for (int i = 0; i < 8; i++) cmp("t1.x_line0", 32'(x_hist[i]), xe[i]);
      cmp("t1.y_v2", 32'(y_hist[16]), 2);
      cmp("t1.act_v2", 32'(act_hist[16]), 1);
      cmp("t1.y_v3", 32'(y_hist[24]), 2);
      cmp("t1.act_v3", 32'(act_hist[24]), 0);
      cmp("t1.y_v5", 32'(y_hist[47]), 2);

      // One strobe in three: all events stretch by exactly 3x
      reset_a();
      run_a(288, 1);
      cmp("t2.line_end_cnt", 32'(le_a), 12);
      cmp("t2.frame_end_cnt", 32'(fe_cyc_a.size()), 2);
      if (fe_cyc_a.size() == 2) begin
         cmp("t2.frame_end_clk0", 32'(fe_cyc_a[0]), 143);
         cmp("t2.frame_end_clk1", 32'(fe_cyc_a[1]), 287);
      end
      cmp("t2.hs_low_cnt", 32'(hsl_a), 72);
      cmp("t2.vs_high_cnt", 32'(vsh_a), 48);
      cmp("t2.frame", 32'(ifa.o_frame), 2);

      // Reset mid-frame at h=5, v=4 with a concurrent strobe
      reset_a();
      run_a(37, 0);
      cmp("t3.pre_hs", 32'(ifa.o_hs), 0);
      cmp("t3.pre_vs", 32'(ifa.o_vs), 1);
      cmp("t3.pre_y", 32'(ifa.o_y), 2);
      rst_a = 1'b1; ifa.i_pix_stb = 1'b1;
      @(posedge i_clk); #1;
      rst_a = 1'b0; ifa.i_pix_stb = 1'b0;
      cmp("t3.x", 32'(ifa.o_x), 0);
      cmp("t3.y", 32'(ifa.o_y), 0);
      cmp("t3.hs", 32'(ifa.o_hs), 1);
      cmp("t3.vs", 32'(ifa.o_vs), 0);
      cmp("t3.frame", 32'(ifa.o_frame), 0);
      cmp("t3.line_end", 32'(ifa.o_line_end), 0);

      // Reset landing on the very last pixel suppresses every strobe and the frame count
      run_a(47, 0);
      rst_a = 1'b1; ifa.i_pix_stb = 1'b1;
      #1;
      cmp("t3b.line_end", 32'(ifa.o_line_end), 0);
      cmp("t3b.frame_end", 32'(ifa.o_frame_end), 0);
      @(posedge i_clk); #1;
      rst_a = 1'b0; ifa.i_pix_stb = 1'b0;
      cmp("t3b.frame", 32'(ifa.o_frame), 0);

      // 2-bit frame counter wraps through 0
      reset_a();
      for (int i = 0; i < 5; i++) begin
         run_a(48, 0);
         cmp("t4.frame_seq", 32'(ifa.o_frame), fseq[i]);
      end

      // 800-pixel lines, 8-line frames, two frames
      cyc_b = 0; le_b = 0; hsl_b = 0; vsl_b = 0; hsf_b = -1;
      fe_cyc_b.delete();
      ifb.i_pix_stb = 1'b1;
      repeat (12800) @(posedge i_clk);
      #1;
      ifb.i_pix_stb = 1'b0;
      cmp("t5.hs_first", 32'(hsf_b), 656);
      cmp("t5.hs_low_cnt", 32'(hsl_b), 1536);
      cmp("t5.vs_low_cnt", 32'(vsl_b), 3200);
      cmp("t5.line_end_cnt", 32'(le_b), 16);
      cmp("t5.frame_end_cnt", 32'(fe_cyc_b.size()), 2);
      if (fe_cyc_b.size() == 2) begin
         cmp("t5.frame_end_clk0", 32'(fe_cyc_b[0]), 6399);
         cmp("t5.frame_end_spacing", 32'(fe_cyc_b[1] - fe_cyc_b[0]), 6400);
      end
      cmp("t5.frame", 32'(ifb.o_frame), 2);

      // Default 640x480 timing, first three lines
      cyc_c = 0; le_c = 0; hsl_c = 0; vsl_c = 0; hsf_c = -1;
      ifc.i_pix_stb = 1'b1;
      repeat (2400) @(posedge i_clk);
      #1;
      ifc.i_pix_stb = 1'b0;
      cmp("t6.hs_first", 32'(hsf_c), 656);
      cmp("t6.hs_low_cnt", 32'(hsl_c), 288);
      cmp("t6.vs_low_cnt", 32'(vsl_c), 0);
      cmp("t6.line_end_cnt", 32'(le_c), 3);
      cmp("t6.y", 32'(ifc.o_y), 3);

      repeat (4) @(posedge i_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
